// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch FSM state, redirect rank encoding and reset PC
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_IDLE
  } fetch_state_t;

  // Numeric order is the arbitration order: a larger value wins
  typedef enum logic [2:0] {
    RK_NONE = 3'd0,
    RK_BR2  = 3'd1,
    RK_BR1  = 3'd2,
    RK_IDLE = 3'd3,
    RK_ERTN = 3'd4,
    RK_EXCP = 3'd5
  } rank_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

endpackage

// File: rtl/redirect_prio_sel.sv
// rtl/redirect_prio_sel.sv - combinational priority select of redirect rank and word-aligned target
module redirect_prio_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              excp_valid,
  input  logic              excp_tlbr,
  input  logic [ADDR_W-1:0] csr_eentry,
  input  logic [ADDR_W-1:0] csr_tlbrentry,
  input  logic              ertn_valid,
  input  logic [ADDR_W-1:0] csr_era,
  input  logic              idle_valid,
  input  logic              br1_valid,
  input  logic [ADDR_W-1:0] br1_target,
  input  logic              br2_valid,
  input  logic [ADDR_W-1:0] br2_target,
  output rank_t             rank,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] raw;

  always_comb begin
    rank = RK_NONE;
    raw  = '0;
    if (excp_valid) begin
      rank = RK_EXCP;
      raw  = excp_tlbr ? csr_tlbrentry : csr_eentry;
    end else if (ertn_valid) begin
      rank = RK_ERTN;
      raw  = csr_era;
    end else if (idle_valid) begin
      rank = RK_IDLE;
    end else if (br1_valid) begin
      rank = RK_BR1;
      raw  = br1_target;
    end else if (br2_valid) begin
      rank = RK_BR2;
      raw  = br2_target;
    end
    target = raw & ~ADDR_W'(3);
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch FSM, pending redirect register and idle PC latch
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ready,
  input  logic              br1_valid,
  input  logic [ADDR_W-1:0] br1_target,
  input  logic              br2_valid,
  input  logic [ADDR_W-1:0] br2_target,
  input  logic              excp_valid,
  input  logic              excp_tlbr,
  input  logic [ADDR_W-1:0] csr_eentry,
  input  logic [ADDR_W-1:0] csr_tlbrentry,
  input  logic              ertn_valid,
  input  logic [ADDR_W-1:0] csr_era,
  input  logic              idle_valid,
  input  logic [ADDR_W-1:0] idle_pc,
  input  logic              int_pending,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_en,
  output logic              idle_o
);

  fetch_state_t      state;
  rank_t             pend_rank;
  rank_t             win_rank;
  logic [ADDR_W-1:0] win_target;
  logic [ADDR_W-1:0] idle_pc_q;
  logic [ADDR_W-1:0] wake_pc;

  redirect_prio_sel #(.ADDR_W(ADDR_W)) u_prio_sel (
    .excp_valid    (excp_valid),
    .excp_tlbr     (excp_tlbr),
    .csr_eentry    (csr_eentry),
    .csr_tlbrentry (csr_tlbrentry),
    .ertn_valid    (ertn_valid),
    .csr_era       (csr_era),
    .idle_valid    (idle_valid),
    .br1_valid     (br1_valid),
    .br1_target    (br1_target),
    .br2_valid     (br2_valid),
    .br2_target    (br2_target),
    .rank          (win_rank),
    .target        (win_target)
  );

  assign wake_pc = (idle_pc_q + ADDR_W'(4)) & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_BOOT;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC & ~ADDR_W'(3);
      pend_rank      <= RK_NONE;
      fetch_en       <= 1'b0;
      idle_o         <= 1'b0;
      idle_pc_q      <= '0;
    end else begin
      case (state)
        // Boot redirect carries exception rank so only an exception may displace it
        ST_BOOT: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= RESET_PC & ~ADDR_W'(3);
          pend_rank      <= RK_EXCP;
          fetch_en       <= 1'b1;
          state          <= ST_RUN;
        end
        ST_RUN, ST_HOLD: begin
          if (redirect_valid && !fetch_ready) begin
            state <= ST_HOLD;
            if (win_rank == RK_EXCP || win_rank > pend_rank) begin
              if (win_rank == RK_IDLE) begin
                // Idle supersedes the held command: wake-up refetches from idle_pc+4 anyway
                redirect_valid <= 1'b0;
                pend_rank      <= RK_NONE;
                idle_pc_q      <= idle_pc;
                fetch_en       <= 1'b0;
                idle_o         <= 1'b1;
                state          <= ST_IDLE;
              end else begin
                redirect_pc <= win_target;
                pend_rank   <= win_rank;
              end
            end
          end else if (win_rank == RK_IDLE) begin
            redirect_valid <= 1'b0;
            pend_rank      <= RK_NONE;
            idle_pc_q      <= idle_pc;
            fetch_en       <= 1'b0;
            idle_o         <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            redirect_valid <= (win_rank != RK_NONE);
            pend_rank      <= win_rank;
            if (win_rank != RK_NONE) redirect_pc <= win_target;
            state <= ST_RUN;
          end
        end
        ST_IDLE: begin
          if (win_rank == RK_EXCP || int_pending) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= (win_rank == RK_EXCP) ? win_target : wake_pc;
            pend_rank      <= (win_rank == RK_EXCP) ? RK_EXCP : RK_IDLE;
            fetch_en       <= 1'b1;
            idle_o         <= 1'b0;
            state          <= ST_RUN;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench: expected redirects queued by stimulus, checked on consumption
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic        br1_valid, br2_valid, excp_valid, excp_tlbr, ertn_valid, idle_valid, int_pending;
  logic [31:0] br1_target, br2_target, csr_eentry, csr_tlbrentry, csr_era, idle_pc;
  logic        redirect_valid, fetch_en, idle_o;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_ready    (fetch_ready),
    .br1_valid      (br1_valid),
    .br1_target     (br1_target),
    .br2_valid      (br2_valid),
    .br2_target     (br2_target),
    .excp_valid     (excp_valid),
    .excp_tlbr      (excp_tlbr),
    .csr_eentry     (csr_eentry),
    .csr_tlbrentry  (csr_tlbrentry),
    .ertn_valid     (ertn_valid),
    .csr_era        (csr_era),
    .idle_valid     (idle_valid),
    .idle_pc        (idle_pc),
    .int_pending    (int_pending),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_en       (fetch_en),
    .idle_o         (idle_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    br1_valid = 0; br2_valid = 0; excp_valid = 0; excp_tlbr = 0;
    ertn_valid = 0; idle_valid = 0; int_pending = 0;
  endtask

  // Every consumed redirect must match the next queued expectation
  always @(negedge clk) begin
    if (!rst && redirect_valid && fetch_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_redirect actual=%h expected=none", redirect_pc);
      end else begin
        chk("consumed_pc", redirect_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1; fetch_ready = 1; clear_req();
    br1_target = 0; br2_target = 0; csr_eentry = 0; csr_tlbrentry = 0; csr_era = 0; idle_pc = 0;
    tick(); tick();
    chk("rst_valid", 32'(redirect_valid), 32'd0);
    chk("rst_pc", redirect_pc, 32'h1c000000);
    chk("rst_fetch_en", 32'(fetch_en), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd0);

    // 1: boot redirect
    exp_q.push_back(32'h1c000000);
    rst = 0;
    tick();
    chk("boot_valid", 32'(redirect_valid), 32'd1);
    chk("boot_fetch_en", 32'(fetch_en), 32'd1);
    tick();

    // 2: exception beats both branches
    br1_valid = 1; br1_target = 32'h1c000100;
    br2_valid = 1; br2_target = 32'h1c000200;
    excp_valid = 1; csr_eentry = 32'h1c008000;
    exp_q.push_back(32'h1c008000);
    tick(); clear_req();
    chk("excp_pc", redirect_pc, 32'h1c008000);
    tick();
    chk("excp_single", 32'(redirect_valid), 32'd0);

    // 3: br2 held, ertn overrides during HOLD
    fetch_ready = 0;
    br2_valid = 1; br2_target = 32'h1c000040;
    tick(); clear_req();
    chk("hold_br2_pc", redirect_pc, 32'h1c000040);
    ertn_valid = 1; csr_era = 32'h1c000080;
    tick(); clear_req();
    chk("hold_ertn_pc", redirect_pc, 32'h1c000080);
    tick();
    chk("hold_stable_valid", 32'(redirect_valid), 32'd1);
    chk("hold_stable_pc", redirect_pc, 32'h1c000080);
    exp_q.push_back(32'h1c000080);
    fetch_ready = 1;
    tick();
    chk("hold_released", 32'(redirect_valid), 32'd0);

    // 4: held tlbr exception not displaced by lower-rank branch
    fetch_ready = 0;
    excp_valid = 1; excp_tlbr = 1; csr_tlbrentry = 32'h1c00f000;
    tick(); clear_req();
    br1_valid = 1; br1_target = 32'h1c000010;
    tick(); clear_req();
    chk("tlbr_kept_pc", redirect_pc, 32'h1c00f000);
    tick();
    chk("tlbr_kept_pc2", redirect_pc, 32'h1c00f000);
    exp_q.push_back(32'h1c00f000);
    fetch_ready = 1;
    tick();

    // 5: idle, ignored branch/ertn, interrupt wake
    idle_valid = 1; idle_pc = 32'h1c000300;
    tick(); clear_req();
    chk("idle_fetch_en", 32'(fetch_en), 32'd0);
    chk("idle_o_set", 32'(idle_o), 32'd1);
    chk("idle_no_redirect", 32'(redirect_valid), 32'd0);
    br1_valid = 1; br1_target = 32'h1c000010;
    ertn_valid = 1; csr_era = 32'h1c000080;
    tick(); clear_req();
    chk("idle_ignores_br", 32'(redirect_valid), 32'd0);
    chk("idle_stays", 32'(idle_o), 32'd1);
    int_pending = 1;
    exp_q.push_back(32'h1c000304);
    tick(); clear_req();
    chk("wake_pc", redirect_pc, 32'h1c000304);
    chk("wake_fetch_en", 32'(fetch_en), 32'd1);
    chk("wake_idle_o", 32'(idle_o), 32'd0);
    tick();

    // exception and interrupt together while idle: exception wins
    idle_valid = 1; idle_pc = 32'h1c000500;
    tick(); clear_req();
    excp_valid = 1; csr_eentry = 32'h1c008000; int_pending = 1;
    exp_q.push_back(32'h1c008000);
    tick(); clear_req();
    chk("idle_excp_pc", redirect_pc, 32'h1c008000);
    tick();

    // 6: alignment and +4 wrap
    br1_valid = 1; br1_target = 32'hfffffffe;
    exp_q.push_back(32'hfffffffc);
    tick(); clear_req();
    chk("align_pc", redirect_pc, 32'hfffffffc);
    tick();
    idle_valid = 1; idle_pc = 32'hfffffffc;
    tick(); clear_req();
    int_pending = 1;
    exp_q.push_back(32'h00000000);
    tick(); clear_req();
    chk("wrap_pc", redirect_pc, 32'h00000000);
    tick();

    // reset in HOLD discards the held branch
    fetch_ready = 0;
    br1_valid = 1; br1_target = 32'h1c000010;
    tick(); clear_req();
    chk("pre_rst_valid", 32'(redirect_valid), 32'd1);
    rst = 1;
    tick();
    chk("mid_rst_valid", 32'(redirect_valid), 32'd0);
    chk("mid_rst_pc", redirect_pc, 32'h1c000000);
    chk("mid_rst_fetch_en", 32'(fetch_en), 32'd0);
    rst = 0;
    tick();
    chk("reboot_pc", redirect_pc, 32'h1c000000);
    exp_q.push_back(32'h1c000000);
    fetch_ready = 1;
    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
